// File: rtl/b_bus_sel_pipe.sv
// ============================================================================
// b_bus_sel_pipe
// ----------------------------------------------------------------------------
// Registered B-bus source multiplexer with a valid/ready output stage.
//
// One of NSRC W-bit sources (0 = PC, 1 = DR, 2.. = R1..) is captured into a
// single-entry output register. The ALU side pulls it with bus_valid/bus_ready.
// An out-of-range select is still consumed, but it produces no bus data. It
// sets a sticky flag and bumps a saturating counter.
//
// Optional feature macro: BBUS_PARITY_EN
//   defined   -> adds output bus_par, the even parity (^B_bus) of the stored
//                word, registered alongside B_bus.
//   undefined -> no bus_par port and no parity logic.
//
// Parameter constraint: 2**SELW must be >= NSRC.
// ============================================================================
module b_bus_sel_pipe #(
    parameter int W    = 16,
    parameter int NSRC = 7,
    parameter int SELW = 3,
    parameter int ERRW = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NSRC*W-1:0]   src_flat,
    input  logic [SELW-1:0]     b_flag,
    input  logic                req,
    output logic                req_ready,
    output logic [W-1:0]        B_bus,
    output logic                bus_valid,
    input  logic                bus_ready,
`ifdef BBUS_PARITY_EN
    output logic                bus_par,
`endif
    output logic                sel_err,
    output logic [ERRW-1:0]     err_cnt,
    input  logic                err_clr
);

    // ------------------------------------------------------------------------
    // Output-stage occupancy
    // ------------------------------------------------------------------------
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

    state_t             state_q,     state_d;
    logic [W-1:0]       b_bus_q,     b_bus_d;
    logic               bus_valid_q, bus_valid_d;
    logic               sel_err_q,   sel_err_d;
    logic [ERRW-1:0]    err_cnt_q,   err_cnt_d;
`ifdef BBUS_PARITY_EN
    logic               bus_par_q,   bus_par_d;
`endif

    // Sources unpacked into an array, so the select loop stays readable
    logic [W-1:0]       src_arr [NSRC];

    logic [W-1:0]       sel_word;
    logic               sel_legal;
    logic               accept;
    logic               consume;
    logic               legal_accept;
    logic               illegal_accept;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src_unpack
            assign src_arr[gi] = src_flat[gi*W +: W];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Handshake terms.
    // req_ready looks only at the registered valid and at bus_ready. There is
    // no path from req or b_flag back into it.
    // ------------------------------------------------------------------------
    assign req_ready      = !bus_valid_q || bus_ready;
    assign accept         = req && req_ready;
    assign consume        = bus_valid_q && bus_ready;
    assign legal_accept   = accept && sel_legal;
    assign illegal_accept = accept && !sel_legal;

    // Decode the select. A code that matches no source leaves sel_legal low.
    always_comb begin
        sel_word  = '0;
        sel_legal = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (b_flag == SELW'(k)) begin
                sel_word  = src_arr[k];
                sel_legal = 1'b1;
            end
        end
    end

    // Next-state for the output register, occupancy FSM and error tracking
    always_comb begin
        state_d     = state_q;
        b_bus_d     = b_bus_q;
        sel_err_d   = sel_err_q;
        err_cnt_d   = err_cnt_q;
`ifdef BBUS_PARITY_EN
        bus_par_d   = bus_par_q;
`endif

        case (state_q)
            ST_EMPTY: begin
                if (legal_accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                // While stalled, no accept can happen because req_ready is 0.
                // A consume either refills (legal accept) or drains.
                if (consume && !legal_accept) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        bus_valid_d = (state_d == ST_FULL);

        // Only a legal accept loads new data. Every other case holds the word.
        if (legal_accept) begin
            b_bus_d = sel_word;
`ifdef BBUS_PARITY_EN
            bus_par_d = ^sel_word;
`endif
        end

        // A clear takes priority. An illegal accept in the same cycle then
        // counts as the first event after the clear.
        if (err_clr) begin
            sel_err_d = illegal_accept;
            err_cnt_d = illegal_accept ? ERRW'(1) : '0;
        end else if (illegal_accept) begin
            sel_err_d = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + ERRW'(1);
            end
        end
    end

    // State register. Reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            b_bus_q     <= '0;
            bus_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            err_cnt_q   <= '0;
`ifdef BBUS_PARITY_EN
            bus_par_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            b_bus_q     <= b_bus_d;
            bus_valid_q <= bus_valid_d;
            sel_err_q   <= sel_err_d;
            err_cnt_q   <= err_cnt_d;
`ifdef BBUS_PARITY_EN
            bus_par_q   <= bus_par_d;
`endif
        end
    end

    assign B_bus     = b_bus_q;
    assign bus_valid = bus_valid_q;
    assign sel_err   = sel_err_q;
    assign err_cnt   = err_cnt_q;
`ifdef BBUS_PARITY_EN
    assign bus_par   = bus_par_q;
`endif

endmodule

// File: tb/tb_b_bus_sel_pipe.sv
// ============================================================================
// tb_b_bus_sel_pipe
// Directed-vector bench for b_bus_sel_pipe with its default parameters
// (W=16, NSRC=7, SELW=3, ERRW=4). Inputs change 1 ns after a rising edge.
// Outputs are sampled at that same point, before any new input is applied.
// ============================================================================
`timescale 1ns/1ps
module tb_b_bus_sel_pipe;

    localparam int W    = 16;
    localparam int NSRC = 7;
    localparam int SELW = 3;
    localparam int ERRW = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NSRC*W-1:0]   src_flat;
    logic [SELW-1:0]     b_flag;
    logic                req;
    logic                req_ready;
    logic [W-1:0]        B_bus;
    logic                bus_valid;
    logic                bus_ready;
`ifdef BBUS_PARITY_EN
    logic                bus_par;
`endif
    logic                sel_err;
    logic [ERRW-1:0]     err_cnt;
    logic                err_clr;

    logic [W-1:0]        src [NSRC];

    int checks   = 0;
    int failures = 0;

    b_bus_sel_pipe #(.W(W), .NSRC(NSRC), .SELW(SELW), .ERRW(ERRW)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_flat  (src_flat),
        .b_flag    (b_flag),
        .req       (req),
        .req_ready (req_ready),
        .B_bus     (B_bus),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
`ifdef BBUS_PARITY_EN
        .bus_par   (bus_par),
`endif
        .sel_err   (sel_err),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_src();
        for (int k = 0; k < NSRC; k++) src_flat[k*W +: W] = src[k];
    endtask

    task automatic base_src();
        for (int k = 0; k < NSRC; k++) src[k] = 16'h1000 + 16'(k);
        pack_src();
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; b_flag = '0; bus_ready = 1'b1; err_clr = 1'b0;
        base_src();
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_bus",       32'(B_bus),     32'h0);
        chk("rst_valid",     32'(bus_valid), 32'h0);
        chk("rst_sel_err",   32'(sel_err),   32'h0);
        chk("rst_err_cnt",   32'(err_cnt),   32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
`ifdef BBUS_PARITY_EN
        chk("rst_par",       32'(bus_par),   32'h0);
`endif

        // Basic select of source 3
        req = 1'b1; b_flag = 3'd3; bus_ready = 1'b1;
        tick();
        chk("basic_bus",   32'(B_bus),     32'h1003);
        chk("basic_valid", 32'(bus_valid), 32'h1);
        req = 1'b0;
        tick();
        chk("basic_drain_valid", 32'(bus_valid), 32'h0);

        // Back-to-back streaming through every source
        for (int k = 0; k < NSRC; k++) begin
            req = 1'b1; b_flag = SELW'(k);
            tick();
            chk($sformatf("stream%0d_bus", k),   32'(B_bus),     32'h1000 + k);
            chk($sformatf("stream%0d_valid", k), 32'(bus_valid), 32'h1);
        end
        req = 1'b0;
        tick();
        chk("stream_drain_valid", 32'(bus_valid), 32'h0);

        // Stall: hold 0x1002 while sources change and a new request waits
        req = 1'b1; b_flag = 3'd2; bus_ready = 1'b0;
        tick();
        chk("stall_load_bus", 32'(B_bus), 32'h1002);
        b_flag = 3'd5;
        for (int k = 0; k < NSRC; k++) src[k] = 16'h2000 + 16'(k);
        pack_src();
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_req_ready", c), 32'(req_ready), 32'h0);
            tick();
            chk($sformatf("stall%0d_bus", c),   32'(B_bus),     32'h1002);
            chk($sformatf("stall%0d_valid", c), 32'(bus_valid), 32'h1);
        end
        bus_ready = 1'b1;
        #1;
        chk("stall_release_req_ready", 32'(req_ready), 32'h1);
        tick();
        chk("stall_release_bus",   32'(B_bus),     32'h2005);
        chk("stall_release_valid", 32'(bus_valid), 32'h1);
        req = 1'b0;
        tick();
        base_src();

        // Reset while full and stalled
        req = 1'b1; b_flag = 3'd4; bus_ready = 1'b0;
        tick();
        chk("rststall_load_bus", 32'(B_bus), 32'h1004);
        req = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rststall_bus",       32'(B_bus),     32'h0);
        chk("rststall_valid",     32'(bus_valid), 32'h0);
        chk("rststall_req_ready", 32'(req_ready), 32'h1);

        // Illegal select: load 0x1001, then 20 accepts of code 7
        req = 1'b1; b_flag = 3'd1; bus_ready = 1'b0;
        tick();
        chk("illegal_pre_bus", 32'(B_bus), 32'h1001);
        bus_ready = 1'b1; b_flag = 3'd7;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("illegal%0d_err_cnt", i), 32'(err_cnt), (i > 15) ? 32'd15 : 32'(i));
        end
        chk("illegal_sel_err", 32'(sel_err),   32'h1);
        chk("illegal_bus",     32'(B_bus),     32'h1001);
        chk("illegal_valid",   32'(bus_valid), 32'h0);
        err_clr = 1'b1;
        tick();
        chk("clr_illegal_err_cnt", 32'(err_cnt), 32'h1);
        chk("clr_illegal_sel_err", 32'(sel_err), 32'h1);
        req = 1'b0;
        tick();
        chk("clr_err_cnt", 32'(err_cnt), 32'h0);
        chk("clr_sel_err", 32'(sel_err), 32'h0);
        err_clr = 1'b0;

`ifdef BBUS_PARITY_EN
        // Parity of the stored word
        src[6] = 16'h0007; src[5] = 16'h0003;
        pack_src();
        req = 1'b1; b_flag = 3'd6;
        tick();
        chk("par_0007_bus", 32'(B_bus),   32'h0007);
        chk("par_0007",     32'(bus_par), 32'h1);
        b_flag = 3'd5;
        tick();
        chk("par_0003_bus", 32'(B_bus),   32'h0003);
        chk("par_0003",     32'(bus_par), 32'h0);
        req = 1'b0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=1 expected=0");
        $fatal(1, "timeout");
    end

endmodule
